interleaver_write_ctrl: RTL and testbench
=========================================

// Module: interleaver_write_ctrl
// PURPOSE
//  Write-side controller for the interleaver block buffer; the counterpart of the strided read-address counter.
//  - Accepts input samples over a valid/ready handshake.
//  - Writes them at sequential addresses into one of two ping-pong banks.
//  - Hands each full bank to the reader, with the block size latched for that block.
//  - Stalls input while the target bank is still owned by the reader.
// PARAMETERS
//  DATA_W     8     sample width
//  ADDR_W     13    in-bank address width (covers 0..6143)
//  SMALL_LEN  1056  samples per block when block_size=0
//  LARGE_LEN  6144  samples per block when block_size=1
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  block_size   in   1       0 small, 1 large; sampled on first accept of a block
//  in_valid     in   1       input sample valid
//  in_data      in   DATA_W  input sample
//  in_ready     out  1       controller can accept in_data this cycle
//  read_done    in   1       1-cycle pulse: reader has released bank read_bank_id
//  read_bank_id in   1       bank released by read_done
//  mem_we       out  1       write strobe to buffer RAM
//  mem_bank     out  1       bank of current write
//  mem_addr     out  ADDR_W  in-bank write address
//  mem_wdata    out  DATA_W  write data
//  blk_ready    out  1       1-cycle pulse: bank blk_bank is full
//  blk_bank     out  1       bank just filled (valid with blk_ready)
//  blk_size     out  1       block_size latched for that bank (valid with blk_ready)
// BEHAVIOUR
//  Reset (async, reset=0):
//   - both banks EMPTY, wr_bank=0, wr_cnt=0.
//   - mem_we=0, mem_bank=0, mem_addr=0, mem_wdata=0, blk_ready=0, blk_bank=0, blk_size=0.
//   - in_ready=0 while reset is asserted.
//  Per-bank state:
//   - EMPTY -> FILLING on first accept.
//   - FILLING -> FULL on last accept.
//   - FULL -> EMPTY on read_done for that bank.
//  Handshake:
//   - Accept when in_valid && in_ready at the clock edge.
//   - in_ready = state[wr_bank] != FULL; combinational from registered state only.
//  Latency: accepted sample appears on mem_we/mem_bank/mem_addr/mem_wdata exactly 1 cycle later (registered).
//  Addressing:
//   - mem_addr = wr_cnt; wr_cnt increments by 1 per accept.
//   - target = LEN-1, with LEN from block_size latched at the EMPTY->FILLING accept.
//   - Mid-block changes of block_size are ignored.
//  Last sample (wr_cnt == target):
//   - Next cycle: write issued, blk_ready=1, blk_bank=wr_bank, blk_size=latched size.
//   - Bank -> FULL, wr_bank toggles, wr_cnt -> 0.
//  Back-to-back: if the other bank is EMPTY, accept continues the cycle after the last sample with no bubble.
//  Both banks FULL: in_ready=0 until a read_done arrives.
//  read_done rules:
//   - read_done for a bank not FULL is ignored.
//   - read_done and last-sample accept on the other bank in the same cycle: both take effect.
//   - read_done for wr_bank in the cycle in_ready=0: in_ready=1 the following cycle.
//  wr_cnt never exceeds target; no wrap inside a bank.
//  Reset mid-block: partial data discarded, no blk_ready issued.
// CONFIGURATION
//  INTERLEAVER_WR_ABORT_EN defined:
//   - adds input port abort (1 bit, 1-cycle pulse).
//   - abort while wr_bank FILLING: bank -> EMPTY, wr_cnt -> 0, wr_bank unchanged, no blk_ready.
//   - a sample accepted in the abort cycle is dropped (no mem_we).
//   - abort while EMPTY or FULL has no effect.
//  Not defined: no abort port; a block can only end by completion or reset.
// TESTING
//  1. Reset, block_size=0, 1056 consecutive valid samples (data=addr[7:0]).
//     -> mem_addr 0..1055 on bank 0, each 1 cycle after accept.
//     -> blk_ready pulse with blk_bank=0, blk_size=0 in the cycle of addr 1055.
//  2. Two large blocks back-to-back, no read_done.
//     -> 12288 accepts, in_ready never drops before the second block's last accept.
//     -> in_ready=0 afterwards, until read_done for bank 0 (in_ready=1 next cycle).
//  3. block_size toggled 0->1 at sample 500 of a small block.
//     -> block still ends at addr 1055, blk_size=0.
//  4. read_done for bank 1 in the same cycle bank 0's last sample is accepted.
//     -> blk_ready for bank 0; bank 1 EMPTY; next accept writes bank 1 addr 0.
//  5. Assert reset at sample 300 of a block.
//     -> all outputs 0 immediately; after release the first write goes to bank 0 addr 0; no blk_ready.
//  6. (INTERLEAVER_WR_ABORT_EN) abort at sample 40.
//     -> next accept writes same bank addr 0; no blk_ready for the aborted block.

Source files
------------

// File: rtl/interleaver_write_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : interleaver_write_ctrl
// Brief    : Ping-pong bank write controller for the interleaver block buffer.
//            Optional abort input enabled by defining INTERLEAVER_WR_ABORT_EN.
// Revision : 1.0
// =============================================================================
module interleaver_write_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 13,
    parameter int SMALL_LEN = 1056,
    parameter int LARGE_LEN = 6144
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef INTERLEAVER_WR_ABORT_EN
    input  logic              i_abort,
`endif
    input  logic              i_block_size,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    input  logic              i_read_done,
    input  logic              i_read_bank_id,
    output logic              o_mem_we,
    output logic              o_mem_bank,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_blk_ready,
    output logic              o_blk_bank,
    output logic              o_blk_size
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_FULL    = 2'd2
    } bank_state_t;

    localparam logic [ADDR_W-1:0] c_SMALL_TGT = ADDR_W'(SMALL_LEN - 1);
    localparam logic [ADDR_W-1:0] c_LARGE_TGT = ADDR_W'(LARGE_LEN - 1);

    bank_state_t        r_state [2];
    logic               r_wr_bank;
    logic [ADDR_W-1:0]  r_wr_cnt;
    logic               r_size_lat;

    bank_state_t        w_cur_state;
    logic               w_accept;
    logic               w_abort;
    logic               w_write;
    logic               w_size;
    logic [ADDR_W-1:0]  w_target;
    logic               w_last;
    logic               w_release;

    assign w_cur_state = r_state[r_wr_bank];

    // Ready depends on registered state only; forced low while reset is held.
    assign o_in_ready  = rst_n && (w_cur_state != S_FULL);
    assign w_accept    = i_in_valid && o_in_ready;

`ifdef INTERLEAVER_WR_ABORT_EN
    assign w_abort     = i_abort && (w_cur_state == S_FILLING);
`else
    assign w_abort     = 1'b0;
`endif

    assign w_write     = w_accept && !w_abort;
    // The first sample of a block takes its size live; later samples use the latch.
    assign w_size      = (w_cur_state == S_EMPTY) ? i_block_size : r_size_lat;
    assign w_target    = w_size ? c_LARGE_TGT : c_SMALL_TGT;
    assign w_last      = w_write && (r_wr_cnt == w_target);
    assign w_release   = i_read_done && (r_state[i_read_bank_id] == S_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0]  <= S_EMPTY;
            r_state[1]  <= S_EMPTY;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_size_lat  <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_bank  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_blk_ready <= 1'b0;
            o_blk_bank  <= 1'b0;
            o_blk_size  <= 1'b0;
        end else begin
            o_mem_we    <= w_write;
            o_blk_ready <= w_last;

            if (w_accept) begin
                o_mem_bank  <= r_wr_bank;
                o_mem_addr  <= r_wr_cnt;
                o_mem_wdata <= i_in_data;
            end

            if (w_last) begin
                o_blk_bank <= r_wr_bank;
                o_blk_size <= w_size;
            end

            // A released bank is FULL, so it is never the bank being written here.
            if (w_release) begin
                r_state[i_read_bank_id] <= S_EMPTY;
            end

            if (w_abort) begin
                r_state[r_wr_bank] <= S_EMPTY;
                r_wr_cnt           <= '0;
            end else if (w_write) begin
                r_size_lat <= w_size;
                if (w_last) begin
                    r_state[r_wr_bank] <= S_FULL;
                    r_wr_bank          <= ~r_wr_bank;
                    r_wr_cnt           <= '0;
                end else begin
                    r_state[r_wr_bank] <= S_FILLING;
                    r_wr_cnt           <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_write_ctrl.sv
`default_nettype none
// Testbench for interleaver_write_ctrl: directed steps with a cycle model and
// scoreboard queues for RAM writes and block-ready events.
module tb_interleaver_write_ctrl;

    localparam int SMALL = 1056;
    localparam int LARGE = 6144;
`ifdef INTERLEAVER_WR_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_block_size = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = '0;
    logic        i_read_done = 1'b0;
    logic        i_read_bank_id = 1'b0;
    wire         o_in_ready;
    wire         o_mem_we;
    wire         o_mem_bank;
    wire  [12:0] o_mem_addr;
    wire  [7:0]  o_mem_wdata;
    wire         o_blk_ready;
    wire         o_blk_bank;
    wire         o_blk_size;

    interleaver_write_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef INTERLEAVER_WR_ABORT_EN
        .i_abort        (i_abort),
`endif
        .i_block_size   (i_block_size),
        .i_in_valid     (i_in_valid),
        .i_in_data      (i_in_data),
        .o_in_ready     (o_in_ready),
        .i_read_done    (i_read_done),
        .i_read_bank_id (i_read_bank_id),
        .o_mem_we       (o_mem_we),
        .o_mem_bank     (o_mem_bank),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_blk_ready    (o_blk_ready),
        .o_blk_bank     (o_blk_bank),
        .o_blk_size     (o_blk_size)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        bank;
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic bank;
        logic size;
    } blk_t;

    wr_t  wq[$];
    blk_t bq[$];

    // Model of the controller: 0 empty, 1 filling, 2 full.
    int   m_state [2];
    int   m_bank;
    int   m_cnt;
    int   m_sz;
    int   m_tgt;
    int   blk_seen = 0;
    wr_t  m_e;
    blk_t m_b;
    logic m_rdy;
    logic m_acc;
    logic m_ab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
            chk("rst_outputs", {6'd0, o_mem_we, o_mem_bank, o_mem_addr, o_mem_wdata,
                                o_blk_ready, o_blk_bank, o_blk_size}, 32'd0);
            wq.delete();
            bq.delete();
            m_state = '{0, 0};
            m_bank  = 0;
            m_cnt   = 0;
            m_sz    = 0;
        end else begin
            chk("mem_we", {31'd0, o_mem_we}, {31'd0, wq.size() != 0});
            if (wq.size() != 0) begin
                m_e = wq.pop_front();
                chk("mem_bank", {31'd0, o_mem_bank}, {31'd0, m_e.bank});
                chk("mem_addr", {19'd0, o_mem_addr}, {19'd0, m_e.addr});
                chk("mem_wdata", {24'd0, o_mem_wdata}, {24'd0, m_e.data});
            end
            chk("blk_ready", {31'd0, o_blk_ready}, {31'd0, bq.size() != 0});
            if (bq.size() != 0) begin
                m_b = bq.pop_front();
                chk("blk_bank", {31'd0, o_blk_bank}, {31'd0, m_b.bank});
                chk("blk_size", {31'd0, o_blk_size}, {31'd0, m_b.size});
            end
            if (o_blk_ready) blk_seen++;

            m_rdy = (m_state[m_bank] != 2);
            chk("in_ready", {31'd0, o_in_ready}, {31'd0, m_rdy});
            m_acc = i_in_valid && m_rdy;
            m_ab  = ABORT_EN && i_abort && (m_state[m_bank] == 1);

            if (i_read_done && m_state[i_read_bank_id] == 2) m_state[i_read_bank_id] = 0;
            if (m_ab) begin
                m_state[m_bank] = 0;
                m_cnt = 0;
            end else if (m_acc) begin
                if (m_state[m_bank] == 0) m_sz = int'(i_block_size);
                wq.push_back({m_bank[0], 13'(m_cnt), i_in_data});
                m_tgt = (m_sz != 0) ? LARGE - 1 : SMALL - 1;
                if (m_cnt == m_tgt) begin
                    bq.push_back({m_bank[0], m_sz[0]});
                    m_state[m_bank] = 2;
                    m_bank = m_bank ^ 1;
                    m_cnt = 0;
                end else begin
                    m_state[m_bank] = 1;
                    m_cnt++;
                end
            end
        end
    end

    // Offer n samples; side pulses fire in the cycle sample index *_at is presented.
    task automatic send(input int n, input logic bs, input int tog_at, input int rd_at,
                        input logic rd_b, input int ab_at, output int cycles);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n + 64) begin
            @(posedge clk);
            #1;
            cyc++;
            i_in_valid     = 1'b1;
            i_in_data      = 8'(got);
            i_block_size   = (tog_at >= 0 && got >= tog_at) ? ~bs : bs;
            i_read_done    = (got == rd_at);
            i_read_bank_id = rd_b;
            i_abort        = (got == ab_at);
            #1;
            if (o_in_ready) got++;
        end
        @(posedge clk);
        #1;
        i_in_valid  = 1'b0;
        i_read_done = 1'b0;
        i_abort     = 1'b0;
        cycles = cyc;
        chk("send_accepts", got, n);
    endtask

    task automatic pulse_rd(input logic b);
        @(posedge clk);
        #1;
        i_read_done    = 1'b1;
        i_read_bank_id = b;
        @(posedge clk);
        #1;
        i_read_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, o_in_ready}, 32'd0);
        chk("reset_mem_we", {31'd0, o_mem_we}, 32'd0);
        rst_n = 1'b1;
        idle(2);
        chk("post_reset_ready", {31'd0, o_in_ready}, 32'd1);

        // Small block into bank 0, data equals address low byte
        send(SMALL, 1'b0, -1, -1, 1'b0, -1, cyc);
        idle(3);
        chk("t1_blk_count", blk_seen, 1);
        pulse_rd(1'b0);

        // block_size flips mid-block on bank 1; block length must not change
        send(SMALL, 1'b0, 500, -1, 1'b0, -1, cyc);
        idle(3);
        chk("t3_blk_count", blk_seen, 2);

        // Bank 0 last sample coincides with release of bank 1
        send(SMALL, 1'b0, -1, SMALL - 1, 1'b1, -1, cyc);
        chk("t4_no_stall", cyc, SMALL);
        send(1, 1'b0, -1, -1, 1'b0, -1, cyc);
        chk("t4_bank1_free", cyc, 1);
        chk("t4_blk_count", blk_seen, 3);

        // Reset with 300 samples in bank 1
        send(299, 1'b0, -1, -1, 1'b0, -1, cyc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_outs_zero", {6'd0, o_mem_we, o_mem_bank, o_mem_addr, o_mem_wdata,
                             o_blk_ready, o_blk_bank, o_blk_size}, 32'd0);
        chk("t5_ready_zero", {31'd0, o_in_ready}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("t5_no_blk", blk_seen, 3);

        // Two large blocks back-to-back, then both banks full
        send(2 * LARGE, 1'b1, -1, -1, 1'b0, -1, cyc);
        chk("t2_no_bubble", cyc, 2 * LARGE);
        chk("t2_stall", {31'd0, o_in_ready}, 32'd0);
        idle(2);
        chk("t2_blk_count", blk_seen, 5);
        chk("t2_still_stall", {31'd0, o_in_ready}, 32'd0);
        i_read_done    = 1'b1;
        i_read_bank_id = 1'b0;
        #1;
        chk("t2_ready_same_cycle", {31'd0, o_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        i_read_done = 1'b0;
        chk("t2_ready_next_cycle", {31'd0, o_in_ready}, 32'd1);

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        if (ABORT_EN) begin
            // Abort at sample 40: the remaining 59 samples restart at address 0
            send(100, 1'b0, -1, -1, 1'b0, 40, cyc);
            idle(2);
            chk("t6_no_blk", blk_seen, 5);
            send(SMALL - 59, 1'b0, -1, -1, 1'b0, -1, cyc);
            idle(3);
            chk("t6_blk_after_abort", blk_seen, 6);
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
